// File: rtl/cms_axis_unpacker.sv
// cms_axis_unpacker: AXI-Stream slave that splits wide monitor trace items
// into OUT_WIDTH-bit words, carrying tlast through as a packet boundary.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   S_AXIS_t*           item input (tvalid/tready/tdata/tlast)
//   words_per_item      words per item; 0 or > WORDS selects WORDS
//   m_valid/m_ready     word output handshake
//   m_data              current word (word i = tdata[i*OUT_WIDTH +: OUT_WIDTH])
//   m_last_word         current word is the final word of its item
//   m_last_pkt          m_last_word of an item that arrived with tlast
//   clr_counters        synchronous clear of both counters
//   item_count          items accepted (wraps)
//   pkt_count           tlast items accepted (wraps)
module cms_axis_unpacker #(
    parameter int IN_WIDTH  = 1024,
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                 S_AXIS_tlast,
    input  logic [4:0]           words_per_item,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last_word,
    output logic                 m_last_pkt,
    input  logic                 clr_counters,
    output logic [31:0]          item_count,
    output logic [31:0]          pkt_count
);

    localparam int WORDS = IN_WIDTH / OUT_WIDTH;
    localparam int NW    = $clog2(WORDS + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              r_state;
    logic [IN_WIDTH-1:0] r_hold;
    logic                r_tlast;
    logic [NW-1:0]       r_n;
    logic [NW-1:0]       r_idx;
    logic [31:0]         r_item_count;
    logic [31:0]         r_pkt_count;

    logic                w_last;
    logic                w_word_hs;
    logic                w_acc;
    logic [NW-1:0]       w_n_eff;

    always_comb begin
        w_n_eff = NW'(WORDS);
        if (words_per_item != 5'd0 && 32'(words_per_item) <= 32'(WORDS))
            w_n_eff = NW'(words_per_item);
    end

    assign m_valid   = (r_state == SEND);
    assign w_last    = (r_idx == r_n - NW'(1));
    assign w_word_hs = m_valid & m_ready;

    // Accept in IDLE, or in the same cycle the final word leaves so that
    // consecutive items stream without a bubble.
    assign S_AXIS_tready = !rst && ((r_state == IDLE) || (w_word_hs && w_last));
    assign w_acc         = S_AXIS_tvalid & S_AXIS_tready;

    // The holding register shifts down as words leave, so the current
    // word is always the low slice and no wide mux is needed.
    assign m_data      = r_hold[OUT_WIDTH-1:0];
    assign m_last_word = m_valid & w_last;
    assign m_last_pkt  = m_last_word & r_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_tlast <= 1'b0;
            r_n     <= '0;
            r_idx   <= '0;
        end else if (w_acc) begin
            r_state <= SEND;
            r_hold  <= S_AXIS_tdata;
            r_tlast <= S_AXIS_tlast;
            r_n     <= w_n_eff;
            r_idx   <= '0;
        end else if (w_word_hs) begin
            if (w_last) begin
                r_state <= IDLE;
            end else begin
                r_idx  <= r_idx + NW'(1);
                r_hold <= r_hold >> OUT_WIDTH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_item_count <= '0;
            r_pkt_count  <= '0;
        end else if (clr_counters) begin
            r_item_count <= '0;
            r_pkt_count  <= '0;
        end else if (w_acc) begin
            r_item_count <= r_item_count + 32'd1;
            if (S_AXIS_tlast)
                r_pkt_count <= r_pkt_count + 32'd1;
        end
    end

    assign item_count = r_item_count;
    assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_cms_axis_unpacker.sv
// tb_cms_axis_unpacker: randomized and directed checks of the unpacker
// against a queue-based word model.
module tb_cms_axis_unpacker;

    typedef struct packed {
        logic [63:0] d;
        logic        lw;
        logic        lp;
    } wd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          S_AXIS_tvalid = 1'b0;
    logic          S_AXIS_tready;
    logic [1023:0] S_AXIS_tdata = '0;
    logic          S_AXIS_tlast = 1'b0;
    logic [4:0]    words_per_item = 5'd16;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [63:0]   m_data;
    logic          m_last_word;
    logic          m_last_pkt;
    logic          clr_counters = 1'b0;
    logic [31:0]   item_count;
    logic [31:0]   pkt_count;

    int nvec = 0;
    int nerr = 0;

    wd_t         exp_q[$];
    wd_t         obs_q[$];
    logic [31:0] mi = '0;
    logic [31:0] mp = '0;
    logic        tr_hi = 1'b0;
    int          tr_err = 0;
    int          stall_err = 0;
    logic        stall_prev = 1'b0;
    wd_t         stall_word = '0;

    cms_axis_unpacker dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .words_per_item(words_per_item),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last_word   (m_last_word),
        .m_last_pkt    (m_last_pkt),
        .clr_counters  (clr_counters),
        .item_count    (item_count),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    function automatic logic [1023:0] rnd_item();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: an accepted item expands into n words, n fixed at accept.
    task automatic model_accept(input logic [1023:0] d, input logic t,
                                input logic [4:0] w);
        int n;
        n = (w == 5'd0 || w > 5'd16) ? 16 : int'(w);
        for (int i = 0; i < n; i++) begin
            wd_t x;
            x.d  = d[i*64 +: 64];
            x.lw = (i == n - 1);
            x.lp = x.lw & t;
            exp_q.push_back(x);
        end
    endtask

    // One clock: sample at negedge, record traffic, return at posedge+1.
    task automatic tick();
        @(negedge clk);
        tr_hi = S_AXIS_tready;
        if (m_valid && (S_AXIS_tready !== (m_ready && m_last_word)))
            tr_err++;
        if (stall_prev && (m_valid !== 1'b1 ||
            wd_t'({m_data, m_last_word, m_last_pkt}) !== stall_word))
            stall_err++;
        stall_prev = m_valid && !m_ready;
        stall_word = {m_data, m_last_word, m_last_pkt};
        if (m_valid && m_ready)
            obs_q.push_back({m_data, m_last_word, m_last_pkt});
        if (S_AXIS_tvalid && S_AXIS_tready)
            model_accept(S_AXIS_tdata, S_AXIS_tlast, words_per_item);
        if (clr_counters) begin
            mi = '0;
            mp = '0;
        end else if (S_AXIS_tvalid && S_AXIS_tready) begin
            mi = mi + 32'd1;
            if (S_AXIS_tlast) mp = mp + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int b = 0;
        S_AXIS_tvalid = 1'b0;
        m_ready = 1'b1;
        while (m_valid && b < 100) begin
            tick();
            b++;
        end
        nvec++;
        if (m_valid !== 1'b0) begin
            nerr++;
            $display("FAIL drain_timeout m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        nvec++;
        if ({S_AXIS_tready, m_valid, m_last_word, m_last_pkt} !== 4'b0 ||
            m_data !== 64'h0) begin
            nerr++;
            $display("FAIL reset_outputs tready=%b valid=%b lw=%b lp=%b data=%h want all 0",
                     S_AXIS_tready, m_valid, m_last_word, m_last_pkt, m_data);
        end
        nvec++;
        if (item_count !== 32'h0 || pkt_count !== 32'h0) begin
            nerr++;
            $display("FAIL reset_counters items=%0d pkts=%0d want 0 0",
                     item_count, pkt_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (S_AXIS_tready !== 1'b1 || m_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release tready=%b valid=%b want 1 0",
                     S_AXIS_tready, m_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [1023:0] d;
        for (int i = 0; i < 16; i++) d[i*64 +: 64] = 64'(i);
        words_per_item = 5'd16;
        S_AXIS_tdata = d;
        S_AXIS_tlast = 1'b1;
        S_AXIS_tvalid = 1'b1;
        tick();
        S_AXIS_tvalid = 1'b0;
        nvec++;
        if (m_valid !== 1'b1 || m_data !== 64'h0) begin
            nerr++;
            $display("FAIL single_latency valid=%b data=%h want 1 0",
                     m_valid, m_data);
        end
        drain();
        nvec++;
        if (obs_q.size() != 16 || exp_q.size() != 16) begin
            nerr++;
            $display("FAIL single_count got %0d want 16", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL single_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        nvec++;
        if (item_count !== 32'd1 || pkt_count !== 32'd1) begin
            nerr++;
            $display("FAIL single_counters items=%0d pkts=%0d want 1 1",
                     item_count, pkt_count);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int nt = 0;
        logic [31:0] base = item_count;
        words_per_item = 5'd1;
        m_ready = 1'b1;
        S_AXIS_tvalid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            S_AXIS_tdata = rnd_item();
            S_AXIS_tlast = 1'($urandom);
            tick();
            if (tr_hi) nt++;
        end
        S_AXIS_tvalid = 1'b0;
        tick();
        nvec++;
        if (nt != 8 || obs_q.size() != 8) begin
            nerr++;
            $display("FAIL b2b_rate tready_cycles=%0d words=%0d want 8 8",
                     nt, obs_q.size());
        end
        drain();
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].lw !== 1'b1) begin
                nerr++;
                $display("FAIL b2b_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        nvec++;
        if (item_count !== base + 32'd8) begin
            nerr++;
            $display("FAIL b2b_items got %0d want %0d", item_count, base + 32'd8);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int ph = 0;
        int nt = 0;
        int b = 0;
        tr_err = 0;
        stall_err = 0;
        words_per_item = 5'd4;
        S_AXIS_tdata = rnd_item();
        S_AXIS_tlast = 1'b0;
        S_AXIS_tvalid = 1'b1;
        tick();
        S_AXIS_tvalid = 1'b0;
        while (m_valid && b < 40) begin
            m_ready = pat[3 - (ph % 4)];
            ph++;
            tick();
            if (tr_hi) nt++;
            b++;
        end
        drain();
        nvec++;
        if (nt != 1 || tr_err != 0) begin
            nerr++;
            $display("FAIL bp_tready high_cycles=%0d rule_errs=%0d want 1 0",
                     nt, tr_err);
        end
        nvec++;
        if (stall_err != 0) begin
            nerr++;
            $display("FAIL bp_stall_hold errs=%0d want 0", stall_err);
        end
        nvec++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            nerr++;
            $display("FAIL bp_count got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL bp_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_wpi_edges();
        logic [4:0] wl[3] = '{5'd0, 5'd20, 5'd4};
        int want[3] = '{16, 16, 4};
        for (int k = 0; k < 3; k++) begin
            words_per_item = wl[k];
            S_AXIS_tdata = rnd_item();
            S_AXIS_tlast = 1'($urandom);
            S_AXIS_tvalid = 1'b1;
            tick();
            S_AXIS_tvalid = 1'b0;
            if (k == 2) begin
                tick();
                words_per_item = 5'd2;
            end
            drain();
            nvec++;
            if (obs_q.size() != want[k] || exp_q.size() != want[k]) begin
                nerr++;
                $display("FAIL wpi%0d_count got %0d want %0d", wl[k],
                         obs_q.size(), want[k]);
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                nvec++;
                if (obs_q[i] !== exp_q[i]) begin
                    nerr++;
                    $display("FAIL wpi%0d_word%0d got %h want %h", wl[k], i,
                             obs_q[i], exp_q[i]);
                end
            end
            obs_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_random();
        tr_err = 0;
        stall_err = 0;
        for (int c = 0; c < 600; c++) begin
            if (!S_AXIS_tvalid || tr_hi) begin
                S_AXIS_tvalid = ($urandom_range(0, 2) != 0);
                S_AXIS_tdata = rnd_item();
                S_AXIS_tlast = 1'($urandom);
                words_per_item = 5'($urandom);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            clr_counters = ($urandom_range(0, 60) == 0);
            tick();
        end
        clr_counters = 1'b0;
        drain();
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL rand_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        nvec++;
        if (item_count !== mi || pkt_count !== mp) begin
            nerr++;
            $display("FAIL rand_counters items=%0d pkts=%0d want %0d %0d",
                     item_count, pkt_count, mi, mp);
        end
        nvec++;
        if (tr_err != 0 || stall_err != 0) begin
            nerr++;
            $display("FAIL rand_rules tready_errs=%0d stall_errs=%0d want 0 0",
                     tr_err, stall_err);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_counter_edges();
        force dut.r_item_count = 32'hFFFF_FFFF;
        force dut.r_pkt_count = 32'hFFFF_FFFF;
        tick();
        release dut.r_item_count;
        release dut.r_pkt_count;
        mi = 32'hFFFF_FFFF;
        mp = 32'hFFFF_FFFF;
        words_per_item = 5'd1;
        S_AXIS_tdata = rnd_item();
        S_AXIS_tlast = 1'b1;
        S_AXIS_tvalid = 1'b1;
        tick();
        S_AXIS_tvalid = 1'b0;
        nvec++;
        if (item_count !== mi || pkt_count !== mp || item_count !== 32'h0) begin
            nerr++;
            $display("FAIL cnt_wrap items=%h pkts=%h want 0 0", item_count, pkt_count);
        end
        drain();
        S_AXIS_tvalid = 1'b1;
        tick();
        tick();
        nvec++;
        if (item_count !== 32'd2 || pkt_count !== 32'd2) begin
            nerr++;
            $display("FAIL cnt_after_wrap items=%0d pkts=%0d want 2 2",
                     item_count, pkt_count);
        end
        clr_counters = 1'b1;
        tick();
        clr_counters = 1'b0;
        S_AXIS_tvalid = 1'b0;
        nvec++;
        if (item_count !== 32'h0 || pkt_count !== 32'h0) begin
            nerr++;
            $display("FAIL cnt_clr_prio items=%0d pkts=%0d want 0 0",
                     item_count, pkt_count);
        end
        drain();
        nvec++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 4) begin
            nerr++;
            $display("FAIL cnt_words got %0d want 4", obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int b = 0;
        int stray = 0;
        words_per_item = 5'd16;
        m_ready = 1'b1;
        S_AXIS_tdata = rnd_item();
        S_AXIS_tlast = 1'b1;
        S_AXIS_tvalid = 1'b1;
        tick();
        S_AXIS_tvalid = 1'b0;
        while (obs_q.size() < 5 && b < 20) begin
            tick();
            b++;
        end
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (m_valid !== 1'b0 || S_AXIS_tready !== 1'b0) begin
            nerr++;
            $display("FAIL rst_async valid=%b tready=%b want 0 0",
                     m_valid, S_AXIS_tready);
        end
        exp_q.delete();
        obs_q.delete();
        mi = '0;
        mp = '0;
        stall_prev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if (S_AXIS_tready !== 1'b0 || item_count !== 32'h0) begin
            nerr++;
            $display("FAIL rst_hold tready=%b items=%0d want 0 0",
                     S_AXIS_tready, item_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (m_valid !== 1'b0) stray++;
        end
        nvec++;
        if (stray != 0 || obs_q.size() != 0) begin
            nerr++;
            $display("FAIL rst_quiet stray_cycles=%0d words=%0d want 0 0",
                     stray, obs_q.size());
        end
        S_AXIS_tdata = rnd_item();
        S_AXIS_tvalid = 1'b1;
        tick();
        S_AXIS_tvalid = 1'b0;
        nvec++;
        if (m_valid !== 1'b1 || m_data !== S_AXIS_tdata[63:0]) begin
            nerr++;
            $display("FAIL rst_new_item valid=%b data=%h want 1 %h",
                     m_valid, m_data, S_AXIS_tdata[63:0]);
        end
        drain();
        nvec++;
        if (obs_q.size() != 16 || exp_q.size() != 16) begin
            nerr++;
            $display("FAIL rst_new_count got %0d want 16", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL rst_new_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wpi_edges();
        test_random();
        test_counter_edges();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
